// File: rtl/crossroad1_core_jtag_cmd_bridge.sv
// rtl/crossroad1_core_jtag_cmd_bridge.sv - JTAG update-DR/IR event bridge with clk-domain command FIFO
module crossroad1_core_jtag_cmd_bridge #(
  parameter int SR_W        = 38,
  parameter int IR_W        = 2,
  parameter int SYNC_STAGES = 2,
  parameter int DEPTH       = 4,
  parameter int ACT_BIT     = SR_W-1,
  parameter int AUTO_POP    = 0,
  localparam int NCH = 2**IR_W,
  localparam int AW  = $clog2(DEPTH),
  localparam int CW  = AW+1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [SR_W-1:0] sr,
  input  logic [IR_W-1:0] ir_in,
  input  logic            vs_udr,
  input  logic            vs_uir,
  input  logic            cmd_ready,
  input  logic            clear_ovf,
  output logic            cmd_valid,
  output logic [SR_W-1:0] jdo,
  output logic [IR_W-1:0] cmd_ch,
  output logic [NCH-1:0]  take_action,
  output logic [NCH-1:0]  take_no_action,
  output logic            ir_strobe,
  output logic            overflow,
  output logic [CW-1:0]   fifo_count
);

  logic [SYNC_STAGES-1:0] udr_sync;
  logic [SYNC_STAGES-1:0] uir_sync;
  logic                   udr_hist;
  logic                   uir_hist;
  logic                   udr_ev;
  logic                   uir_ev;

  logic [IR_W+SR_W-1:0]   mem [DEPTH];
  logic [AW-1:0]          wptr;
  logic [AW-1:0]          rptr;
  logic                   full;
  logic                   pop;
  logic                   push;
  logic                   drop;
  logic [IR_W+SR_W-1:0]   head;
  logic [SR_W-1:0]        head_sr;
  logic [IR_W-1:0]        head_ch;
  logic [NCH-1:0]         ch_onehot;

  // Bring the TCK-domain update levels into clk and keep one cycle of history for edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      udr_sync <= '0;
      uir_sync <= '0;
      udr_hist <= 1'b0;
      uir_hist <= 1'b0;
    end else begin
      udr_sync <= {udr_sync[SYNC_STAGES-2:0], vs_udr};
      uir_sync <= {uir_sync[SYNC_STAGES-2:0], vs_uir};
      udr_hist <= udr_sync[SYNC_STAGES-1];
      uir_hist <= uir_sync[SYNC_STAGES-1];
    end
  end

  assign udr_ev = udr_sync[SYNC_STAGES-1] & ~udr_hist;
  assign uir_ev = uir_sync[SYNC_STAGES-1] & ~uir_hist;

  assign full      = (fifo_count == CW'(DEPTH));
  assign cmd_valid = (fifo_count != '0);
  assign pop       = cmd_valid && (cmd_ready || (AUTO_POP != 0));
  // A pop on the same edge frees the slot, so a push into a full FIFO still lands
  assign push      = udr_ev && (!full || pop);
  assign drop      = udr_ev && full && !pop;

  assign head      = mem[rptr];
  assign head_sr   = head[SR_W-1:0];
  assign head_ch   = head[SR_W +: IR_W];
  assign ch_onehot = NCH'(1) << head_ch;

  // Command storage; contents are don't-care after reset since pointers define validity
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr] <= {ir_in, sr};
    end
  end

  // Pointers wrap naturally at the power-of-two depth; occupancy tracks push/pop balance
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr       <= '0;
      rptr       <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      if (push && !pop)      fifo_count <= fifo_count + CW'(1);
      else if (!push && pop) fifo_count <= fifo_count - CW'(1);
    end
  end

  // Registered outputs: popped command fields, per-channel strobes, IR pulse and sticky overflow
  always_ff @(posedge clk) begin
    if (reset) begin
      jdo            <= '0;
      cmd_ch         <= '0;
      take_action    <= '0;
      take_no_action <= '0;
      ir_strobe      <= 1'b0;
      overflow       <= 1'b0;
    end else begin
      ir_strobe      <= uir_ev;
      take_action    <= '0;
      take_no_action <= '0;
      if (drop)           overflow <= 1'b1;
      else if (clear_ovf) overflow <= 1'b0;
      if (pop) begin
        jdo    <= head_sr;
        cmd_ch <= head_ch;
        if (head_sr[ACT_BIT]) take_action    <= ch_onehot;
        else                  take_no_action <= ch_onehot;
      end
    end
  end

endmodule
